// File: rtl/fifo.sv
// Synchronous FIFO, 2^AddrBits words deep, with first-word fall-through read data.
// Latency: a written word is visible on r_data_o the cycle after the write edge; reads are zero-latency pops.
// Backpressure: full_o refuses lone writes, empty_o refuses reads; write+read while full pops and pushes together.
module fifo #(
  parameter int Width    = 8,
  parameter int AddrBits = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [Width-1:0] w_data_i,
  output logic [Width-1:0] r_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int Depth = 1 << AddrBits;

  // Storage is deliberately not reset; the flags alone say what is valid.
  logic [Width-1:0]    mem_q [Depth];
  logic [AddrBits-1:0] wr_ptr_q;
  logic [AddrBits-1:0] rd_ptr_q;
  logic [AddrBits-1:0] wr_ptr_nxt;
  logic [AddrBits-1:0] rd_ptr_nxt;
  logic                empty_q;
  logic                full_q;
  logic                do_wr;
  logic                do_rd;

  // Qualify requests: a read needs data, and a write needs room unless a read frees a slot in the same edge.
  always_comb begin
    do_rd      = rd_i & ~empty_q & ~rst_i;
    do_wr      = wr_i & (~full_q | rd_i) & ~rst_i;
    wr_ptr_nxt = wr_ptr_q + AddrBits'(1);
    rd_ptr_nxt = rd_ptr_q + AddrBits'(1);
  end

  // Write port. When full with a concurrent read, wr_ptr equals rd_ptr, so the new word lands in the slot being popped.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= w_data_i;
    end
  end

  // Pointer registers; both wrap naturally at 2^AddrBits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_nxt;
      if (do_rd) rd_ptr_q <= rd_ptr_nxt;
    end
  end

  // Registered flags. Equal pointers are ambiguous, so the flags are decided by which side moved last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      unique case ({do_wr, do_rd})
        2'b10: begin
          empty_q <= 1'b0;
          full_q  <= (wr_ptr_nxt == rd_ptr_q);
        end
        2'b01: begin
          full_q  <= 1'b0;
          empty_q <= (rd_ptr_nxt == wr_ptr_q);
        end
        default: begin
          // Idle, or a balanced push+pop: occupancy and flags unchanged.
          empty_q <= empty_q;
          full_q  <= full_q;
        end
      endcase
    end
  end

  // Head of queue is presented combinationally; value is meaningless while empty.
  always_comb begin
    r_data_o = mem_q[rd_ptr_q];
    empty_o  = empty_q;
    full_o   = full_q;
  end

  // The two flags describe mutually exclusive occupancies.
  flags_exclusive : assert property (@(posedge clk_i) disable iff (rst_i) !(empty_q && full_q));

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: table-driven flag/data vectors plus queue scoreboard.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after edges.
// Depth 8, width 8 (default parameters).
module tb_fifo;

  logic       clk_i;
  logic       rst_i;
  logic       wr_i;
  logic       rd_i;
  logic [7:0] w_data_i;
  logic [7:0] r_data_o;
  logic       empty_o;
  logic       full_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] sb[$];

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    bit         chk_dat;
    logic [7:0] exp_dat;
    bit         exp_empty;
    bit         exp_full;
  } vec_t;

  vec_t vecs[$];

  fifo #(.Width(8), .AddrBits(3)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (wr_i),
    .rd_i     (rd_i),
    .w_data_i (w_data_i),
    .r_data_o (r_data_o),
    .empty_o  (empty_o),
    .full_o   (full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // One clock of stimulus. Data is checked before the edge (fall-through head),
  // flags after it. Flag expectations come from the table or from the scoreboard depth.
  task automatic step(input bit wr, input bit rd, input logic [7:0] din, input bit use_tab,
                      input bit chk_dat, input logic [7:0] exp_dat, input bit exp_e,
                      input bit exp_f, input string tag);
    bit         rd_ok;
    bit         wr_ok;
    logic [7:0] head;
    @(negedge clk_i);
    wr_i     = wr;
    rd_i     = rd;
    w_data_i = din;
    #1;
    rd_ok = rd && (sb.size() > 0);
    wr_ok = wr && ((sb.size() < 8) || rd);
    if (rd_ok) begin
      head = sb.pop_front();
      check({tag, " sb_data"}, {24'h0, r_data_o}, {24'h0, head});
    end
    if (use_tab && chk_dat) check({tag, " tab_data"}, {24'h0, r_data_o}, {24'h0, exp_dat});
    if (wr_ok) sb.push_back(din);
    @(posedge clk_i);
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    if (use_tab) begin
      check({tag, " empty"}, {31'h0, empty_o}, {31'h0, exp_e});
      check({tag, " full"},  {31'h0, full_o},  {31'h0, exp_f});
    end else begin
      check({tag, " empty"}, {31'h0, empty_o}, {31'h0, sb.size() == 0});
      check({tag, " full"},  {31'h0, full_o},  {31'h0, sb.size() == 8});
    end
  endtask

  task automatic op(input bit wr, input bit rd, input logic [7:0] din, input string tag);
    step(wr, rd, din, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst_i    = 1'b1;
    wr_i     = 1'b0;
    rd_i     = 1'b0;
    w_data_i = 8'h00;

    // Idle, empty read pulse, writes 0..7 with idle gaps, ignored 9th write, eight reads.
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    for (int k = 0; k < 8; k++) begin
      vecs.push_back('{1'b1, 1'b0, 8'(k), 1'b0, 8'h00, 1'b0, (k == 7)});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, (k == 7)});
    end
    vecs.push_back('{1'b1, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1});
    for (int k = 0; k < 8; k++) begin
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'(k), (k == 7), 1'b0});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, (k == 7), 1'b0});
    end

    // Reset state, visible without a clock edge.
    #1;
    check("reset empty", {31'h0, empty_o}, 32'h1);
    check("reset full",  {31'h0, full_o},  32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b1, vecs[i].chk_dat, vecs[i].exp_dat,
           vecs[i].exp_empty, vecs[i].exp_full, $sformatf("vec%0d", i));
    end

    // Wrap-around: pointers move 5 slots, then a full fill crosses the end of the array.
    for (int k = 0; k < 5; k++) op(1'b1, 1'b0, 8'(20 + k), "wrap_pre_wr");
    for (int k = 0; k < 5; k++) op(1'b0, 1'b1, 8'h00, "wrap_pre_rd");
    for (int k = 0; k < 8; k++) op(1'b1, 1'b0, 8'(8'h10 + k), "wrap_wr");
    check("wrap full", {31'h0, full_o}, 32'h1);
    for (int k = 0; k < 8; k++) op(1'b0, 1'b1, 8'h00, "wrap_rd");

    // Simultaneous read+write at occupancy 3.
    for (int k = 0; k < 3; k++) op(1'b1, 1'b0, 8'(8'h30 + k), "rw3_fill");
    for (int k = 0; k < 4; k++) op(1'b1, 1'b1, 8'(8'h40 + k), "rw3_both");
    for (int k = 0; k < 3; k++) op(1'b0, 1'b1, 8'h00, "rw3_drain");

    // Simultaneous read+write while empty: write only.
    op(1'b1, 1'b1, 8'h50, "rw_empty");
    check("rw_empty empty", {31'h0, empty_o}, 32'h0);

    // Simultaneous read+write while full: pop head, append, stay full.
    for (int k = 1; k < 8; k++) op(1'b1, 1'b0, 8'(8'h50 + k), "rwf_fill");
    op(1'b1, 1'b1, 8'h60, "rw_full");
    check("rw_full full", {31'h0, full_o}, 32'h1);
    for (int k = 0; k < 8; k++) op(1'b0, 1'b1, 8'h00, "rwf_drain");

    // Asynchronous reset between edges with 4 entries stored.
    for (int k = 0; k < 4; k++) op(1'b1, 1'b0, 8'(8'h70 + k), "arst_fill");
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst empty", {31'h0, empty_o}, 32'h1);
    check("arst full",  {31'h0, full_o},  32'h0);
    wr_i     = 1'b1;
    w_data_i = 8'hEE;
    @(posedge clk_i);
    #1;
    check("arst wr ignored", {31'h0, empty_o}, 32'h1);
    @(negedge clk_i);
    rst_i = 1'b0;
    wr_i  = 1'b0;
    sb.delete();
    #1;
    check("post_rst empty", {31'h0, empty_o}, 32'h1);
    check("post_rst full",  {31'h0, full_o},  32'h0);
    op(1'b1, 1'b0, 8'h77, "post_rst_wr");
    op(1'b0, 1'b1, 8'h00, "post_rst_rd");
    check("scoreboard drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
